// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } fetch_state_t;

  localparam int unsigned PC_INCR          = 4;
  localparam int unsigned RESET_PC_DEFAULT = 0;
endpackage

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing and IF/ID register with stall and redirect
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          ADDRESS_SIZE = 10,
  parameter int unsigned RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_i,
  input  logic                    redirect_i,
  input  logic [ADDRESS_SIZE+1:0] redirect_pc_i,
  output logic [ADDRESS_SIZE-1:0] imem_addr,
  output logic                    imem_read_en,
  input  logic [WIDTH-1:0]        imem_instruction,
  output logic                    if_valid,
  output logic [ADDRESS_SIZE+1:0] if_pc,
  output logic [WIDTH-1:0]        if_instr,
  output logic [31:0]             fetch_count
);

  localparam int PC_W = ADDRESS_SIZE + 2;
  localparam logic [PC_W-1:0] RESET_PC_W     = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] RESET_PC_ALIGN = {RESET_PC_W[PC_W-1:2], 2'b00};

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc;
  logic            unused_redirect_low;

  // Byte-offset bits of the target are dropped; only the word address matters.
  assign unused_redirect_low = ^redirect_pc_i[1:0];
  assign imem_addr           = pc[PC_W-1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    imem_read_en = 1'b0;
    unique case (state)
      IDLE: state_next = RUN;
      RUN: begin
        imem_read_en = !stall_i && !redirect_i;
        if (stall_i && !redirect_i) state_next = HOLD;
      end
      HOLD: begin
        if (!stall_i || redirect_i) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Redirect beats stall, stall beats sequential fetch; any non-fetch cycle that is not a stall inserts a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC_ALIGN;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      fetch_count <= '0;
    end else if (redirect_i) begin
      pc       <= {redirect_pc_i[PC_W-1:2], 2'b00};
      if_valid <= 1'b0;
    end else if (!stall_i) begin
      if (imem_read_en) begin
        pc          <= pc + PC_W'(PC_INCR);
        if_valid    <= 1'b1;
        if_pc       <= pc;
        if_instr    <= imem_instruction;
        fetch_count <= fetch_count + 32'd1;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed table and randomized model check of fetch_controller
module tb_fetch_controller;
  localparam int AW = 10;
  localparam int PW = AW + 2;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [PW-1:0] redirect_pc_i = '0;
  logic [AW-1:0] imem_addr;
  logic          imem_read_en;
  logic [W-1:0]  imem_instruction;
  logic          if_valid;
  logic [PW-1:0] if_pc;
  logic [W-1:0]  if_instr;
  logic [31:0]   fetch_count;

  logic [W-1:0] mem [1 << AW];

  fetch_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr        (imem_addr),
    .imem_read_en     (imem_read_en),
    .imem_instruction (imem_instruction),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_instruction = mem[imem_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [11:0] tgt;
    logic        ren;
    logic        v;
    logic [11:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic run_vec(input int i);
    stall_i       = vecs[i].s;
    redirect_i    = vecs[i].r;
    redirect_pc_i = vecs[i].tgt;
    #1;
    check($sformatf("vec%0d_read_en", i), 32'(imem_read_en), 32'(vecs[i].ren));
    @(posedge clk);
    @(negedge clk);
    check($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].v));
    check($sformatf("vec%0d_count", i), fetch_count, vecs[i].cnt);
    if (vecs[i].v) begin
      check($sformatf("vec%0d_pc", i), 32'(if_pc), 32'(vecs[i].pc));
      check($sformatf("vec%0d_instr", i), if_instr, vecs[i].instr);
    end
  endtask

  // Reference model: plain spec rules, one call per rising edge
  logic [PW-1:0] m_pc;
  logic          m_valid;
  logic [PW-1:0] m_ifpc;
  logic [31:0]   m_instr;
  logic [31:0]   m_cnt;
  logic          m_idle;
  logic          m_held;

  function automatic void model_reset();
    m_pc = '0; m_valid = 1'b0; m_ifpc = '0; m_instr = '0; m_cnt = '0;
    m_idle = 1'b1; m_held = 1'b0;
  endfunction

  function automatic logic model_fetch(input logic s, input logic r);
    return !m_idle && !m_held && !s && !r;
  endfunction

  function automatic void model_edge(input logic s, input logic r, input logic [PW-1:0] tgt);
    logic f;
    f = model_fetch(s, r);
    if (r) begin
      m_pc    = tgt & ~PW'(3);
      m_valid = 1'b0;
    end else if (!s) begin
      if (f) begin
        m_valid = 1'b1;
        m_ifpc  = m_pc;
        m_instr = 32'(m_pc / 4);
        m_pc    = PW'((int'(m_pc) + 4) % (1 << PW));
        m_cnt   = m_cnt + 1;
      end else begin
        m_valid = 1'b0;
      end
    end
    m_held = !m_idle && s && !r;
    m_idle = 1'b0;
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = W'(i);

    //              s     r     tgt      ren   v     pc       instr   cnt
    vecs[0]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0,   32'd0};
    vecs[1]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 32'h0,   32'd1};
    vecs[2]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h004, 32'h1,   32'd2};
    vecs[3]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h008, 32'h2,   32'd3};
    vecs[4]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h008, 32'h2,   32'd3};
    vecs[5]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h008, 32'h2,   32'd3};
    vecs[6]  = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h008, 32'h2,   32'd3};
    vecs[7]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h008, 32'h2,   32'd3};
    vecs[8]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h00C, 32'h3,   32'd4};
    vecs[9]  = '{1'b0, 1'b1, 12'h100, 1'b0, 1'b0, 12'h00C, 32'h3,   32'd4};
    vecs[10] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h100, 32'h40,  32'd5};
    vecs[11] = '{1'b1, 1'b1, 12'h023, 1'b0, 1'b0, 12'h100, 32'h40,  32'd5};
    vecs[12] = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h100, 32'h40,  32'd5};
    vecs[13] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h100, 32'h40,  32'd5};
    vecs[14] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h020, 32'h8,   32'd6};
    vecs[15] = '{1'b0, 1'b1, 12'hFFC, 1'b0, 1'b0, 12'h020, 32'h8,   32'd6};
    vecs[16] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'hFFC, 32'h3FF, 32'd7};
    vecs[17] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 32'h0,   32'd8};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_if_pc", 32'(if_pc), 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_read_en", 32'(imem_read_en), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(i);

    // Asynchronous reset mid-stall, held through a redirect
    stall_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(if_valid), 32'd0);
    check("async_count", fetch_count, 32'd0);
    check("async_if_pc", 32'(if_pc), 32'd0);
    check("async_read_en", 32'(imem_read_en), 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 12'h200;
    @(negedge clk);
    check("async_addr", 32'(imem_addr), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(i);

    // Randomized run against the reference model
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic          s, r;
      logic [PW-1:0] tgt;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rnd_rst_valid", 32'(if_valid), 32'd0);
        check("rnd_rst_count", fetch_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      s   = ($urandom_range(0, 9) < 3);
      r   = ($urandom_range(0, 9) == 0);
      tgt = PW'($urandom);
      stall_i       = s;
      redirect_i    = r;
      redirect_pc_i = tgt;
      #1;
      check("rnd_read_en", 32'(imem_read_en), 32'(model_fetch(s, r)));
      check("rnd_addr", 32'(imem_addr), 32'(m_pc[PW-1:2]));
      @(posedge clk);
      model_edge(s, r, tgt);
      @(negedge clk);
      check("rnd_valid", 32'(if_valid), 32'(m_valid));
      check("rnd_count", fetch_count, m_cnt);
      if (m_valid) begin
        check("rnd_if_pc", 32'(if_pc), 32'(m_ifpc));
        check("rnd_instr", if_instr, m_instr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
